// File: rtl/dg0045_pkg.sv
// Shared constants and state encoding for the DG0045 RAM front end.
package dg0045_pkg;

    localparam int unsigned DG_ADDR_W = 6;
    localparam int unsigned DG_DATA_W = 4;
    localparam int unsigned DG_DEPTH  = 64;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dg0045_rr_arb2.sv
// Two-way round-robin pick: favours the port that was not granted last.
module dg0045_rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic win,
    output logic any
);

    // Winner select; win is only meaningful when any is high
    always_comb begin
        any = req0 | req1;
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last_gnt;
        end else if (req1) begin
            win = 1'b1;
        end
    end

endmodule

// File: rtl/dg0045_ram_arbiter.sv
// Clears the DG0045 RAM after reset, then shares its single port between
// the puzzle-logic side (port 0) and the display-scan side (port 1).
module dg0045_ram_arbiter
    import dg0045_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DG_ADDR_W,
    parameter int unsigned        DATA_W   = DG_DATA_W,
    parameter int unsigned        DEPTH    = DG_DEPTH,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              init_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    // One extra bit so the terminal compare can see DEPTH itself
    localparam int unsigned CNT_W = ADDR_W + 1;

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              last_gnt_q, last_gnt_d;
    logic              init_done_d;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [DATA_W-1:0] din_hold_q;
    logic              rd0_fire, rd1_fire;
    logic              arb_win, arb_any;

    dg0045_rr_arb2 u_rr_arb2 (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt_q),
        .win      (arb_win),
        .any      (arb_any)
    );

    // Next state, sweep counter, grant decode and RAM port mux
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + CNT_W'(1);
        last_gnt_d  = last_gnt_q;
        init_done_d = init_done;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        rd0_fire    = 1'b0;
        rd1_fire    = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = addr_hold_q;
        ram_din     = din_hold_q;
        if (sys_rst) begin
            ram_addr = '0;
            ram_din  = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ram_we   = 1'b1;
                    ram_addr = cnt_q[ADDR_W-1:0];
                    ram_din  = INIT_VAL;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == CNT_W'(DEPTH)) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (arb_any) begin
                        last_gnt_d = arb_win;
                        if (arb_win) begin
                            gnt1     = 1'b1;
                            ram_addr = addr1;
                            ram_we   = we1;
                            ram_din  = we1 ? wdata1 : '0;
                            rd1_fire = ~we1;
                        end else begin
                            gnt0     = 1'b1;
                            ram_addr = addr0;
                            ram_we   = we0;
                            ram_din  = we0 ? wdata0 : '0;
                            rd0_fire = ~we0;
                        end
                    end
                end
            endcase
        end
    end

    // State, counter and arbitration history
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            init_done  <= init_done_d;
        end
    end

    // Remember the last driven address/data so idle cycles keep the bus steady
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            addr_hold_q <= '0;
            din_hold_q  <= '0;
        end else begin
            addr_hold_q <= ram_addr;
            din_hold_q  <= ram_din;
        end
    end

    // Read return: capture RAM data at the end of the grant cycle
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= rd0_fire;
            rvalid1 <= rd1_fire;
            if (rd0_fire) begin
                rdata0 <= ram_dout;
            end
            if (rd1_fire) begin
                rdata1 <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_dg0045_ram_arbiter.sv
// Directed bench for dg0045_ram_arbiter with a behavioural 64x4 RAM.
module tb_dg0045_ram_arbiter;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       req0, we0, req1, we1;
    logic [5:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, init_done, ram_we;
    logic [3:0] rdata0, rdata1, ram_din, ram_dout;
    logic [5:0] ram_addr;

    int vectors = 0;
    int miscompares = 0;

    // Pre-filled with non-zero junk so the clear sweep is observable
    logic [3:0] mem [64] = '{default: 4'h5};

    always #5 sys_clk = ~sys_clk;

    // Combinational-read RAM, written on the clock edge
    always @(posedge sys_clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    dg0045_ram_arbiter dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rdata0    (rdata0),
        .rvalid0   (rvalid0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rdata1    (rdata1),
        .rvalid1   (rvalid1),
        .init_done (init_done),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic mid;
        @(negedge sys_clk);
    endtask

    initial begin
        sys_rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'd7; wdata1 = '0;
        repeat (3) next_cycle();

        // Reset values, with port 1 already requesting
        mid();
        chk("rst_ram_we", 8'(ram_we), 8'd0);
        chk("rst_init_done", 8'(init_done), 8'd0);
        chk("rst_gnt0", 8'(gnt0), 8'd0);
        chk("rst_gnt1", 8'(gnt1), 8'd0);
        chk("rst_rvalid0", 8'(rvalid0), 8'd0);
        chk("rst_rvalid1", 8'(rvalid1), 8'd0);
        chk("rst_rdata0", 8'(rdata0), 8'd0);
        chk("rst_ram_addr", 8'(ram_addr), 8'd0);
        next_cycle();
        sys_rst = 1'b0;

        // Clear sweep: 64 writes of 0, port 1 held off
        for (int i = 0; i < 64; i++) begin
            mid();
            chk("sweep_we", 8'(ram_we), 8'd1);
            chk("sweep_addr", 8'(ram_addr), 8'(i));
            chk("sweep_din", 8'(ram_din), 8'd0);
            chk("sweep_gnt1", 8'(gnt1), 8'd0);
            chk("sweep_done", 8'(init_done), 8'd0);
            next_cycle();
        end
        mid();
        chk("run_init_done", 8'(init_done), 8'd1);
        chk("run_first_gnt1", 8'(gnt1), 8'd1);
        chk("run_first_addr", 8'(ram_addr), 8'd7);
        chk("run_first_we", 8'(ram_we), 8'd0);
        next_cycle();
        req1 = 1'b0;
        mid();
        chk("p1_rvalid", 8'(rvalid1), 8'd1);
        chk("p1_rdata_cleared", 8'(rdata1), 8'd0);
        chk("p1_gnt_idle", 8'(gnt1), 8'd0);
        next_cycle();

        // Port 0 write 5 <- A, then read it back
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 4'hA;
        mid();
        chk("wr5_gnt0", 8'(gnt0), 8'd1);
        chk("wr5_we", 8'(ram_we), 8'd1);
        chk("wr5_addr", 8'(ram_addr), 8'd5);
        chk("wr5_din", 8'(ram_din), 8'hA);
        chk("wr5_rvalid1_gone", 8'(rvalid1), 8'd0);
        next_cycle();
        we0 = 1'b0;
        mid();
        chk("rd5_gnt0", 8'(gnt0), 8'd1);
        chk("rd5_we", 8'(ram_we), 8'd0);
        chk("rd5_din", 8'(ram_din), 8'd0);
        chk("rd5_rvalid_not_yet", 8'(rvalid0), 8'd0);
        next_cycle();
        req0 = 1'b0;
        mid();
        chk("rd5_rvalid", 8'(rvalid0), 8'd1);
        chk("rd5_rdata", 8'(rdata0), 8'hA);
        chk("idle_gnt0", 8'(gnt0), 8'd0);
        chk("idle_addr_hold", 8'(ram_addr), 8'd5);
        chk("idle_we", 8'(ram_we), 8'd0);
        next_cycle();
        mid();
        chk("rvalid0_pulse_end", 8'(rvalid0), 8'd0);
        chk("rdata0_holds", 8'(rdata0), 8'hA);
        next_cycle();

        // Port 1 write 9 <- 3, leaves last grant on port 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'd9; wdata1 = 4'h3;
        mid();
        chk("wr9_gnt1", 8'(gnt1), 8'd1);
        chk("wr9_addr", 8'(ram_addr), 8'd9);
        next_cycle();

        // Both ports reading: grants alternate starting with port 0
        we1 = 1'b0; addr1 = 6'd5;
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd9;
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("rr_gnt0", 8'(gnt0), (k % 2 == 0) ? 8'd1 : 8'd0);
            chk("rr_gnt1", 8'(gnt1), (k % 2 == 1) ? 8'd1 : 8'd0);
            chk("rr_addr", 8'(ram_addr), (k % 2 == 0) ? 8'd9 : 8'd5);
            chk("rr_rvalid0", 8'(rvalid0), (k % 2 == 1) ? 8'd1 : 8'd0);
            chk("rr_rvalid1", 8'(rvalid1), (k > 0 && k % 2 == 0) ? 8'd1 : 8'd0);
            if (k > 0) chk("rr_rdata0", 8'(rdata0), 8'h3);
            if (k > 1) chk("rr_rdata1", 8'(rdata1), 8'hA);
            next_cycle();
        end
        req0 = 1'b0; req1 = 1'b0;
        mid();
        chk("rr_tail_rvalid1", 8'(rvalid1), 8'd1);
        chk("rr_tail_rvalid0", 8'(rvalid0), 8'd0);
        next_cycle();

        // Top address boundary, then address 0 still holds the clear value
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd63; wdata0 = 4'hF;
        mid();
        chk("wr63_din", 8'(ram_din), 8'hF);
        next_cycle();
        we0 = 1'b0;
        mid();
        chk("rd63_addr", 8'(ram_addr), 8'd63);
        next_cycle();
        addr0 = 6'd0;
        mid();
        chk("rd63_rvalid", 8'(rvalid0), 8'd1);
        chk("rd63_rdata", 8'(rdata0), 8'hF);
        chk("rd0_gnt0", 8'(gnt0), 8'd1);
        next_cycle();
        req0 = 1'b0;
        mid();
        chk("rd0_rvalid", 8'(rvalid0), 8'd1);
        chk("rd0_rdata", 8'(rdata0), 8'h0);
        next_cycle();

        // Port 1 write then port 0 read of the same word on the next cycle
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'd20; wdata1 = 4'h6;
        mid();
        chk("wr20_gnt1", 8'(gnt1), 8'd1);
        next_cycle();
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 6'd20;
        mid();
        chk("rd20_gnt0", 8'(gnt0), 8'd1);
        next_cycle();
        req0 = 1'b0;
        mid();
        chk("rd20_rdata", 8'(rdata0), 8'h6);
        next_cycle();

        // Reset in RUN, then again mid-sweep at cnt=30 restarts from address 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd63;
        sys_rst = 1'b1;
        mid();
        chk("rst2_we", 8'(ram_we), 8'd0);
        chk("rst2_gnt0", 8'(gnt0), 8'd0);
        next_cycle();
        sys_rst = 1'b0;
        for (int i = 0; i < 30; i++) next_cycle();
        mid();
        chk("pre_rst_addr30", 8'(ram_addr), 8'd30);
        next_cycle();
        // Sweep has already advanced to 31; re-issue the pulse at cnt=30 on a clean restart
        sys_rst = 1'b1;
        next_cycle();
        sys_rst = 1'b0;
        for (int i = 0; i < 30; i++) next_cycle();
        sys_rst = 1'b1;
        mid();
        chk("rst3_we", 8'(ram_we), 8'd0);
        next_cycle();
        sys_rst = 1'b0;
        for (int j = 0; j < 64; j++) begin
            mid();
            chk("resweep_addr", 8'(ram_addr), 8'(j));
            chk("resweep_done", 8'(init_done), 8'd0);
            chk("resweep_gnt0", 8'(gnt0), 8'd0);
            next_cycle();
        end
        mid();
        chk("resweep_init_done", 8'(init_done), 8'd1);
        chk("resweep_gnt0_first", 8'(gnt0), 8'd1);
        next_cycle();
        req0 = 1'b0;
        mid();
        chk("rd63_after_clear", 8'(rdata0), 8'h0);
        chk("rd63_after_clear_v", 8'(rvalid0), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
